// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// Patterns are active-low with bit 6 = segment a down to bit 0 = segment g.
package seg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Status-screen letters; N and R are the lowercase shapes a 7-segment can show.
    localparam logic [6:0] LET_N = 7'b1101010;
    localparam logic [6:0] LET_E = 7'b0110000;
    localparam logic [6:0] LET_R = 7'b1111010;
    localparam logic [6:0] LET_P = 7'b0011000;
    localparam logic [6:0] LET_X = 7'b1001000;
    localparam logic [6:0] LET_O = 7'b0000001;
    localparam logic [6:0] LET_T = 7'b1110000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'b0000001;
            4'h1:    pattern = 7'b1001111;
            4'h2:    pattern = 7'b0010010;
            4'h3:    pattern = 7'b0000110;
            4'h4:    pattern = 7'b1001100;
            4'h5:    pattern = 7'b0100100;
            4'h6:    pattern = 7'b0100000;
            4'h7:    pattern = 7'b0001111;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0000100;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b1100000;
            4'hC:    pattern = 7'b0110001;
            4'hD:    pattern = 7'b1000010;
            4'hE:    pattern = 7'b0110000;
            default: pattern = 7'b0111000;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low a..g segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit common-anode 7-segment driver with PWM brightness.
// Content is double-buffered and swapped only at the frame boundary so a frame never tears.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE_W = 17,
    parameter int DUTY_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [7*DIGITS-1:0]   raw,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DUTY_W-1:0]     brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef struct packed {
        logic                  mode;
        logic [4*DIGITS-1:0]   data;
        logic [7*DIGITS-1:0]   raw;
        logic [DIGITS-1:0]     dp;
        logic [DIGITS-1:0]     blank;
    } content_t;

    // Everything blanked so nothing lights until the first committed load.
    localparam content_t CONTENT_RST = '{mode: 1'b0, data: '0, raw: '0, dp: '0, blank: '1};

    logic [PRESCALE_W-1:0] presc;
    logic [IDX_W-1:0]      idx;
    content_t              pend;
    content_t              act;

    logic                  slot_end;
    logic                  frame_end;
    logic                  enable;
    logic [DUTY_W-1:0]     phase;
    logic [3:0]            nibble;
    logic [6:0]            hex_pat;
    logic [6:0]            pattern;

    assign slot_end  = &presc;
    assign frame_end = slot_end && (idx == '0);
    assign phase     = presc[PRESCALE_W-1 -: DUTY_W];

    // Prescaler 0 is a dead cycle between slots to suppress ghosting.
    assign enable = !act.blank[idx] && (phase <= brightness) && (presc != '0);

    assign nibble  = act.data[4*int'(idx) +: 4];
    assign pattern = act.mode ? act.raw[7*int'(idx) +: 7] : hex_pat;

    seg_hex_decode u_hex (
        .nibble  (nibble),
        .pattern (hex_pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= IDX_LAST;
            pend       <= CONTENT_RST;
            act        <= CONTENT_RST;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            presc      <= presc + PRESCALE_W'(1);
            frame_done <= frame_end;

            if (slot_end) begin
                idx <= (idx == '0) ? IDX_LAST : idx - IDX_W'(1);
            end

            // Active takes the pre-edge pending value; a load on this edge waits a frame.
            if (frame_end) begin
                act <= pend;
            end
            if (load) begin
                pend <= '{mode: mode, data: data, raw: raw, dp: dp_in, blank: blank};
            end

            if (enable) begin
                an  <= ~(DIGITS'(1) << idx);
                seg <= pattern;
                dp  <= ~act.dp[idx];
            end else begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end
        end
    end

endmodule
